// File: rtl/systolic_matmul_nxn.sv
// systolic_matmul_nxn: NxN output-stationary systolic multiplier C = A x B, signed Qm.FRAC_W, round half up + saturate
// Ports: clk, reset_n (async active-low), start (sampled in IDLE), a_flat/b_flat (element (i,j) at [(i*N+j)*DATA_W +: DATA_W]),
//        c_flat (registered result, same packing), busy, done (1-cycle pulse),
//        ovf (per-element saturation flags, present only when SYSTOLIC_OVF_FLAG_EN is defined)
module systolic_matmul_nxn #(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [N*N*DATA_W-1:0] a_flat,
  input  logic [N*N*DATA_W-1:0] b_flat,
  output logic [N*N*DATA_W-1:0] c_flat,
  output logic                  busy,
  output logic                  done
`ifdef SYSTOLIC_OVF_FLAG_EN
  ,
  output logic [N*N-1:0]        ovf
`endif
);
  localparam int ACC_W = 2*DATA_W + $clog2(N);
  // Operands skew in over t=0..3N-3; PE input registers add one hop, so the final MAC lands at t=3N-2
  // and the result is written at the close of t=3N-1, giving done 3N+1 edges after start.
  localparam int LAST = 3*N - 1;
  localparam int TW = $clog2(3*N);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2**(DATA_W-1)));
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [TW-1:0] t;
  logic signed [DATA_W-1:0] a_q [N][N];
  logic signed [DATA_W-1:0] b_q [N][N];
  logic signed [DATA_W-1:0] a_pe [N][N];
  logic signed [DATA_W-1:0] b_pe [N][N];
  logic signed [ACC_W-1:0] acc [N][N];
  logic signed [2*DATA_W-1:0] prod [N][N];
  logic signed [DATA_W-1:0] west [N];
  logic signed [DATA_W-1:0] north [N];
  logic signed [ACC_W-1:0] r;
  logic [N*N*DATA_W-1:0] res;
  logic [N*N-1:0] sat;
  assign busy = state == RUN || state == DONE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? LOAD : IDLE) :
               state == LOAD ? RUN :
               state == RUN  ? (int'(t) == LAST ? DONE : RUN) : IDLE;
  end
  // Row i sees A[i][t-i] and column j sees B[t-j][j]; zero outside the skew window.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      west[i] = '0;
      north[i] = '0;
      for (int k = 0; k < N; k++) begin
        if (state == RUN && int'(t) == i + k) begin
          west[i] = a_q[i][k];
          north[i] = b_q[k][i];
        end
      end
    end
  end
  always_comb begin
    r = '0;
    res = '0;
    sat = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = (2*DATA_W)'(a_pe[i][j]) * (2*DATA_W)'(b_pe[i][j]);
        r = (acc[i][j] + HALF) >>> FRAC_W;
        sat[i*N+j] = r > MAXV || r < MINV;
        res[(i*N+j)*DATA_W +: DATA_W] = sat[i*N+j] ? (r[ACC_W-1] ? MINV[DATA_W-1:0] : MAXV[DATA_W-1:0]) : r[DATA_W-1:0];
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      t <= '0;
      c_flat <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      a_pe <= '{default: '0};
      b_pe <= '{default: '0};
      acc <= '{default: '0};
`ifdef SYSTOLIC_OVF_FLAG_EN
      ovf <= '0;
`endif
    end else begin
      state <= state_nx;
      t <= state == RUN ? t + TW'(1) : '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (state == IDLE && start) begin
            a_q[i][j] <= a_flat[(i*N+j)*DATA_W +: DATA_W];
            b_q[i][j] <= b_flat[(i*N+j)*DATA_W +: DATA_W];
          end
          if (state == LOAD) begin
            acc[i][j] <= '0;
            a_pe[i][j] <= '0;
            b_pe[i][j] <= '0;
          end else if (state == RUN) begin
            // The modulo keeps the index legal; the j==0 / i==0 arm never uses it.
            a_pe[i][j] <= j == 0 ? west[i] : a_pe[i][(j+N-1)%N];
            b_pe[i][j] <= i == 0 ? north[j] : b_pe[(i+N-1)%N][j];
            acc[i][j] <= acc[i][j] + ACC_W'(prod[i][j]);
          end
        end
      end
      if (state == RUN && int'(t) == LAST) begin
        c_flat <= res;
`ifdef SYSTOLIC_OVF_FLAG_EN
        ovf <= sat;
`endif
      end
    end
  end
endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// tb_systolic_matmul_nxn: checks N=3, N=2 and N=8 instances against an arithmetic reference model
module tb_systolic_matmul_nxn;
  logic clk = 0;
  logic reset_n = 0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [2:0] start_all = '0;
  logic [511:0] a_all [3];
  logic [511:0] b_all [3];
  logic [71:0] c3;
  logic [31:0] c2;
  logic [511:0] c8;
  logic busy3, busy2, busy8, done3, done2, done8;
  logic [511:0] c_all [3];
  logic [2:0] busy_all, done_all;
`ifdef SYSTOLIC_OVF_FLAG_EN
  logic [8:0] o3;
  logic [3:0] o2;
  logic [63:0] o8;
  logic [63:0] o_all [3];
`endif
  systolic_matmul_nxn #(.N(3), .DATA_W(8), .FRAC_W(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start_all[0]), .a_flat(a_all[0][71:0]), .b_flat(b_all[0][71:0]),
    .c_flat(c3), .busy(busy3), .done(done3)
`ifdef SYSTOLIC_OVF_FLAG_EN
    , .ovf(o3)
`endif
  );
  systolic_matmul_nxn #(.N(2), .DATA_W(8), .FRAC_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start_all[1]), .a_flat(a_all[1][31:0]), .b_flat(b_all[1][31:0]),
    .c_flat(c2), .busy(busy2), .done(done2)
`ifdef SYSTOLIC_OVF_FLAG_EN
    , .ovf(o2)
`endif
  );
  systolic_matmul_nxn #(.N(8), .DATA_W(8), .FRAC_W(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start_all[2]), .a_flat(a_all[2]), .b_flat(b_all[2]),
    .c_flat(c8), .busy(busy8), .done(done8)
`ifdef SYSTOLIC_OVF_FLAG_EN
    , .ovf(o8)
`endif
  );
  always_comb begin
    c_all[0] = 512'(c3);
    c_all[1] = 512'(c2);
    c_all[2] = c8;
    busy_all = {busy8, busy2, busy3};
    done_all = {done8, done2, done3};
`ifdef SYSTOLIC_OVF_FLAG_EN
    o_all[0] = 64'(o3);
    o_all[1] = 64'(o2);
    o_all[2] = o8;
`endif
  end
  function automatic int nn(int k);
    return k == 0 ? 3 : k == 1 ? 2 : 8;
  endfunction
  // Q3.4 matrix product with round-half-up and saturation, straight from the arithmetic definition.
  function automatic logic [511:0] ref_c(int n, logic [511:0] a, logic [511:0] b, output logic [63:0] o);
    logic [511:0] c = '0;
    longint s;
    logic [7:0] ea, eb;
    o = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          ea = a[(i*n+k)*8 +: 8];
          eb = b[(k*n+j)*8 +: 8];
          s += longint'($signed(ea)) * longint'($signed(eb));
        end
        s = (s + 8) >>> 4;
        if (s > 127) begin s = 127; o[i*n+j] = 1'b1; end
        else if (s < -128) begin s = -128; o[i*n+j] = 1'b1; end
        c[(i*n+j)*8 +: 8] = 8'(s);
      end
    end
    return c;
  endfunction
  task automatic chk(string nm, int n, logic [511:0] got, logic [511:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s n=%0d got=%0h want=%0h at %0t", nm, n, got, want, $time);
    end
  endtask
  // Transaction-level model: an accepted start yields busy for edges 1..3N+1, done at 3N+1, result from then on.
  bit act [3];
  int since [3];
  logic [511:0] exp_c [3];
  logic [511:0] pend_c [3];
  logic [63:0] exp_o [3];
  logic [63:0] pend_o [3];
  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        act[k] = 0;
        since[k] = 0;
        exp_c[k] = '0;
        exp_o[k] = '0;
      end else if (act[k]) begin
        since[k]++;
        if (since[k] == 3*nn(k)+1) begin
          exp_c[k] = pend_c[k];
          exp_o[k] = pend_o[k];
        end
        if (since[k] == 3*nn(k)+2) act[k] = 0;
      end else if (start_all[k]) begin
        act[k] = 1;
        since[k] = 0;
        pend_c[k] = ref_c(nn(k), a_all[k], b_all[k], pend_o[k]);
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("busy", nn(k), 512'(busy_all[k]), 512'(act[k] && since[k] >= 1 && since[k] <= 3*nn(k)+1));
      chk("done", nn(k), 512'(done_all[k]), 512'(act[k] && since[k] == 3*nn(k)+1));
      chk("c_flat", nn(k), c_all[k], exp_c[k]);
`ifdef SYSTOLIC_OVF_FLAG_EN
      chk("ovf", nn(k), 512'(o_all[k]), 512'(exp_o[k]));
`endif
    end
  end
  task automatic op(int k, logic [511:0] a, logic [511:0] b, output int lat);
    @(posedge clk); #2;
    a_all[k] = a;
    b_all[k] = b;
    start_all[k] = 1'b1;
    @(posedge clk); #2;
    start_all[k] = 1'b0;
    a_all[k] = {16{$urandom}};
    b_all[k] = {16{$urandom}};
    lat = 0;
    while (!done_all[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  initial begin
    int lat, nd;
    logic [511:0] a1, b1, c1, a, b, e;
    logic [63:0] o;
    for (int k = 0; k < 3; k++) begin
      a_all[k] = '0;
      b_all[k] = '0;
    end
    repeat (3) @(posedge clk);
    #2 reset_n = 1;
    #1;
    chk("rst_c", 3, c_all[0], '0);
    chk("rst_busy", 3, 512'(busy_all), '0);
    chk("rst_done", 3, 512'(done_all), '0);
    a1 = '0; b1 = '0; c1 = '0;
    a1[71:0] = {8'h10, 8'h08, 8'hFC, 8'hE8, 8'h10, 8'h08, 8'h10, 8'h08, 8'h08};
    b1[71:0] = {8'h08, 8'h08, 8'h10, 8'h10, 8'h10, 8'h10, 8'h28, 8'h28, 8'h10};
    c1[71:0] = {8'h06, 8'h06, 8'h14, 8'h18, 8'h18, 8'h00, 8'h24, 8'h24, 8'h20};
    chk("model_worked", 3, ref_c(3, a1, b1, o), c1);
    op(0, a1, b1, lat);
    chk("lat_worked", 3, 512'(lat), 512'(10));
    chk("c_worked", 3, c_all[0], c1);
`ifdef SYSTOLIC_OVF_FLAG_EN
    chk("ovf_worked", 3, 512'(o_all[0]), '0);
`endif
    a = '0;
    a[71:0] = {8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10};
    op(0, a, b1, lat);
    chk("c_identity", 3, c_all[0], b1);
    a = '0; b = '0; e = '0;
    for (int i = 0; i < 9; i++) begin a[i*8 +: 8] = 8'h7F; b[i*8 +: 8] = 8'h7F; e[i*8 +: 8] = 8'h7F; end
    op(0, a, b, lat);
    chk("c_sat_pos", 3, c_all[0], e);
`ifdef SYSTOLIC_OVF_FLAG_EN
    chk("ovf_sat_pos", 3, 512'(o_all[0]), 512'(9'h1FF));
`endif
    for (int i = 0; i < 9; i++) begin a[i*8 +: 8] = 8'h80; e[i*8 +: 8] = 8'h80; end
    op(0, a, b, lat);
    chk("c_sat_neg", 3, c_all[0], e);
`ifdef SYSTOLIC_OVF_FLAG_EN
    chk("ovf_sat_neg", 3, 512'(o_all[0]), 512'(9'h1FF));
`endif
    a = '0; b = '0; e = '0;
    a[7:0] = 8'h01;
    b[7:0] = 8'h08;
    e[7:0] = 8'h01;
    chk("model_round", 3, ref_c(3, a, b, o), e);
    op(0, a, b, lat);
    chk("c_round", 3, c_all[0], e);
    @(posedge clk); #2;
    a_all[0] = a1; b_all[0] = b1; start_all[0] = 1'b1;
    @(posedge clk); #2;
    start_all[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 start_all[0] = 1'b1;
    @(posedge clk); #2;
    start_all[0] = 1'b0;
    nd = 0;
    repeat (20) begin @(posedge clk); #1; nd += int'(done_all[0]); end
    chk("one_done", 3, 512'(nd), 512'(1));
    chk("c_after_ignored", 3, c_all[0], c1);
    a = '0;
    a[71:0] = {8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10};
    @(posedge clk); #2;
    a_all[0] = a; b_all[0] = b1; start_all[0] = 1'b1;
    @(posedge clk); #2;
    start_all[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 3, 512'(busy_all[0]), '0);
    chk("abort_done", 3, 512'(done_all[0]), '0);
    chk("abort_c", 3, c_all[0], '0);
    @(posedge clk); #2 reset_n = 1'b1;
    nd = 0;
    repeat (15) begin @(posedge clk); #1; nd += int'(done_all[0]); end
    chk("abort_no_done", 3, 512'(nd), '0);
    op(0, a1, b1, lat);
    chk("c_after_abort", 3, c_all[0], c1);
    @(posedge clk); #2;
    a_all[0] = a1; b_all[0] = b1; start_all[0] = 1'b1;
    nd = 0;
    repeat (25) begin @(posedge clk); #1; nd += int'(done_all[0]); end
    #1 start_all[0] = 1'b0;
    chk("held_start_dones", 3, 512'(nd), 512'(2));
    repeat (15) @(posedge clk);
    a = '0; b = '0; e = '0;
    a[31:0] = {8'h10, 8'h00, 8'h10, 8'h10};
    b[31:0] = {8'h30, 8'h00, 8'h00, 8'h20};
    e[31:0] = {8'h30, 8'h00, 8'h30, 8'h20};
    chk("model_n2", 2, ref_c(2, a, b, o), e);
    op(1, a, b, lat);
    chk("lat_n2", 2, 512'(lat), 512'(7));
    chk("c_n2", 2, c_all[1], e);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        a = '0; b = '0;
        for (int x = 0; x < nn(k)*nn(k); x++) begin
          a[x*8 +: 8] = r[0] ? 8'($urandom_range(32) - 16) : 8'($urandom);
          b[x*8 +: 8] = r[0] ? 8'($urandom_range(32) - 16) : 8'($urandom);
        end
        op(k, a, b, lat);
        chk("lat_sweep", nn(k), 512'(lat), 512'(3*nn(k)+1));
      end
    end
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
